// File: rtl/cmp_pkg.sv
// Shared types, result encoding and sizing helper for the digit-serial magnitude comparator.
package cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    // One-hot result encoding, ordered {gt, eq, lt}
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/seq_mag_comparator_if.sv
// Request/result bundle of the digit-serial magnitude comparator.
interface seq_mag_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;

    modport master (
        output start, a, b,
        input  busy, done, gt, eq, lt
    );

    modport slave (
        input  start, a, b,
        output busy, done, gt, eq, lt
    );
endinterface

// File: rtl/digit_cmp.sv
// Combinational magnitude compare of one DIGIT-wide slice; equal when both flags are low.
module digit_cmp #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_digit,
    input  logic [DIGIT-1:0] b_digit,
    output logic             dgt,
    output logic             dlt
);
    assign dgt = (a_digit > b_digit);
    assign dlt = (a_digit < b_digit);
endmodule

// File: rtl/seq_mag_comparator.sv
// Digit-serial MSB-first magnitude comparator with early termination on the first differing digit.
// Define SEQ_MAG_COMPARATOR_SIGNED_EN for two's-complement operands (MSB flip at latch time).
module seq_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_mag_comparator_if.slave  bus
);
    localparam int N     = num_digits(WIDTH, DIGIT);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [2:0]       res_reg, res_next;
    logic             done_reg, done_next;

    logic [WIDTH-1:0] a_load;
    logic [WIDTH-1:0] b_load;

`ifdef SEQ_MAG_COMPARATOR_SIGNED_EN
    // Flipping both sign bits maps two's complement order onto unsigned order
    assign a_load = bus.a ^ {1'b1, {(WIDTH-1){1'b0}}};
    assign b_load = bus.b ^ {1'b1, {(WIDTH-1){1'b0}}};
`else
    assign a_load = bus.a;
    assign b_load = bus.b;
`endif

    logic [DIGIT-1:0] a_digits [N];
    logic [DIGIT-1:0] b_digits [N];
    logic [DIGIT-1:0] a_cur;
    logic [DIGIT-1:0] b_cur;
    logic             dgt;
    logic             dlt;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign a_digits[gi] = a_reg[gi*DIGIT +: DIGIT];
            assign b_digits[gi] = b_reg[gi*DIGIT +: DIGIT];
        end
    endgenerate

    assign a_cur = a_digits[idx_reg];
    assign b_cur = b_digits[idx_reg];

    digit_cmp #(
        .DIGIT (DIGIT)
    ) u_digit_cmp (
        .a_digit (a_cur),
        .b_digit (b_cur),
        .dgt     (dgt),
        .dlt     (dlt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= RES_NONE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            res_reg   <= res_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        res_next   = res_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    a_next     = a_load;
                    b_next     = b_load;
                    idx_next   = IDX_TOP;
                    res_next   = RES_NONE;
                    state_next = CMP;
                end
            end
            CMP: begin
                if (dgt) begin
                    res_next   = RES_GT;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (dlt) begin
                    res_next   = RES_LT;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (idx_reg == '0) begin
                    res_next   = RES_EQ;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    idx_next = idx_reg - IDX_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy = (state_reg == CMP);
    assign bus.done = done_reg;
    assign bus.gt   = res_reg[2];
    assign bus.eq   = res_reg[1];
    assign bus.lt   = res_reg[0];

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Scoreboard bench for seq_mag_comparator: 8-bit/2-bit-digit instance plus an exhaustive 2-bit/1-bit instance.
module tb_seq_mag_comparator;

    typedef struct {
        logic [2:0] res;
        int         lat;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb8[$];
    exp_t sb2[$];

    always #5 clk = ~clk;

    seq_mag_comparator_if #(.WIDTH(8)) bus8 ();
    seq_mag_comparator_if #(.WIDTH(2)) bus2 ();

    seq_mag_comparator #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    seq_mag_comparator #(.WIDTH(2), .DIGIT(1)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Reference order: plain integer compare, sign-extended by hand in the signed build
    function automatic logic [2:0] ref_res(input logic [31:0] a, input logic [31:0] b, input int w);
        longint sa = longint'(a);
        longint sb = longint'(b);
`ifdef SEQ_MAG_COMPARATOR_SIGNED_EN
        if (a[w-1]) sa = sa - (longint'(1) << w);
        if (b[w-1]) sb = sb - (longint'(1) << w);
`endif
        if (sa > sb)  return 3'b100;
        if (sa == sb) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input int w, input int d);
        int n = w / d;
        logic [31:0] diff = a ^ b;
        logic [31:0] mask = (32'd1 << d) - 32'd1;
        for (int k = 0; k < n; k++) begin
            if (((diff >> ((n - 1 - k) * d)) & mask) != 32'd0) return k + 1;
        end
        return n;
    endfunction

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input string name);
        exp_t e;
        e.res  = ref_res({24'd0, a}, {24'd0, b}, 8);
        e.lat  = ref_lat({24'd0, a}, {24'd0, b}, 8, 2);
        e.name = name;
        sb8.push_back(e);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        checks++;
        if (bus8.busy !== 1'b1 || {bus8.gt, bus8.eq, bus8.lt} !== 3'b000) begin
            errors++;
            $display("FAIL %s accept: busy=%b res=%b, required busy=1 res=000",
                     name, bus8.busy, {bus8.gt, bus8.eq, bus8.lt});
        end
    endtask

    task automatic wait_done8(output logic [2:0] res_out);
        exp_t e;
        int   cyc = 0;
        bit   seen = 0;
        e = sb8.pop_front();
        res_out = e.res;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(posedge clk); #1;
            if (bus8.done === 1'b1) begin
                seen = 1;
                cyc  = c;
            end else begin
                checks++;
                if (bus8.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_early_drop: busy=%b at cycle %0d, required 1", e.name, bus8.busy, c);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: no done within 8 cycles, required done at cycle %0d", e.name, e.lat);
        end else begin
            if (cyc != e.lat) begin
                errors++;
                $display("FAIL %s latency: got %0d, required %0d", e.name, cyc, e.lat);
            end
            checks++;
            if ({bus8.gt, bus8.eq, bus8.lt} !== e.res) begin
                errors++;
                $display("FAIL %s result: gt/eq/lt=%b, required %b", e.name, {bus8.gt, bus8.eq, bus8.lt}, e.res);
            end
            checks++;
            if (bus8.busy !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_fall: busy=%b on done edge, required 0", e.name, bus8.busy);
            end
        end
        $display("txn w8 %s res=%b lat=%0d exp_res=%b exp_lat=%0d",
                 e.name, {bus8.gt, bus8.eq, bus8.lt}, cyc, e.res, e.lat);
    endtask

    task automatic check_hold8(input logic [2:0] res, input string name);
        @(posedge clk); #1;
        checks++;
        if (bus8.done !== 1'b0 || bus8.busy !== 1'b0 || {bus8.gt, bus8.eq, bus8.lt} !== res) begin
            errors++;
            $display("FAIL %s hold: done=%b busy=%b res=%b, required done=0 busy=0 res=%b",
                     name, bus8.done, bus8.busy, {bus8.gt, bus8.eq, bus8.lt}, res);
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input string name);
        logic [2:0] r;
        issue8(a, b, name);
        wait_done8(r);
        check_hold8(r, name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus2.start = 1'b0; bus2.a = '0; bus2.b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus8.busy, bus8.done, bus8.gt, bus8.eq, bus8.lt} !== 5'b0 ||
            {bus2.busy, bus2.done, bus2.gt, bus2.eq, bus2.lt} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state: w8=%b w2=%b, required 00000",
                     {bus8.busy, bus8.done, bus8.gt, bus8.eq, bus8.lt},
                     {bus2.busy, bus2.done, bus2.gt, bus2.eq, bus2.lt});
        end
        rst = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_directed();
        run8(8'hA5, 8'h35, "a5_35");
        run8(8'h5A, 8'h5A, "eq_5a");
        run8(8'h12, 8'h13, "12_13");
        run8(8'hFF, 8'h01, "ff_01");
        run8(8'h80, 8'h7F, "80_7f");
        run8(8'h00, 8'h00, "eq_00");
        run8(8'hFF, 8'hFF, "eq_ff");
        run8(8'h7F, 8'h80, "7f_80");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [2:0] r;
        issue8(8'h80, 8'h00, "b2b_first");
        // Request while busy must be ignored
        bus8.start = 1'b1;
        bus8.a     = 8'h00;
        bus8.b     = 8'hFF;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        e = sb8.pop_front();
        checks++;
        if (bus8.done !== 1'b1 || {bus8.gt, bus8.eq, bus8.lt} !== e.res) begin
            errors++;
            $display("FAIL %s ignore_busy_start: done=%b res=%b, required done=1 res=%b",
                     e.name, bus8.done, {bus8.gt, bus8.eq, bus8.lt}, e.res);
        end
        $display("txn w8 %s res=%b exp_res=%b", e.name, {bus8.gt, bus8.eq, bus8.lt}, e.res);
        // Still in the done cycle: this request is accepted
        issue8(8'h00, 8'h00, "b2b_done_cycle");
        wait_done8(r);
        check_hold8(r, "b2b_done_cycle");
    endtask

    task automatic test_reset_mid();
        issue8(8'h5A, 8'h5A, "rst_mid");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb8.delete();
        checks++;
        if ({bus8.busy, bus8.done, bus8.gt, bus8.eq, bus8.lt} !== 5'b0) begin
            errors++;
            $display("FAIL rst_mid clear: busy/done/gt/eq/lt=%b, required 00000",
                     {bus8.busy, bus8.done, bus8.gt, bus8.eq, bus8.lt});
        end
        $display("txn w8 rst_mid discarded");
        run8(8'h01, 8'h02, "after_rst_01_02");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            logic [7:0] a = 8'($urandom);
            logic [7:0] b = a ^ (8'(1) << $urandom_range(0, 7));
            if (i % 4 == 3) b = a;
            run8(a, b, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_exhaustive_w2();
        for (int ia = 0; ia < 4; ia++) begin
            for (int ib = 0; ib < 4; ib++) begin
                exp_t e;
                int   cyc = 0;
                bit   seen = 0;
                e.res  = ref_res(32'(ia), 32'(ib), 2);
                e.lat  = ref_lat(32'(ia), 32'(ib), 2, 1);
                e.name = $sformatf("w2_%0d_%0d", ia, ib);
                sb2.push_back(e);
                bus2.start = 1'b1;
                bus2.a     = 2'(ia);
                bus2.b     = 2'(ib);
                @(posedge clk); #1;
                bus2.start = 1'b0;
                bus2.a     = 2'($urandom);
                bus2.b     = 2'($urandom);
                for (int c = 1; c <= 5 && !seen; c++) begin
                    @(posedge clk); #1;
                    if (bus2.done === 1'b1) begin
                        seen = 1;
                        cyc  = c;
                    end
                end
                e = sb2.pop_front();
                checks++;
                if (!seen || cyc != e.lat) begin
                    errors++;
                    $display("FAIL %s latency: got %0d (seen=%0b), required %0d", e.name, cyc, seen, e.lat);
                end
                checks++;
                if ({bus2.gt, bus2.eq, bus2.lt} !== e.res ||
                    $countones({bus2.gt, bus2.eq, bus2.lt}) != 1) begin
                    errors++;
                    $display("FAIL %s result: gt/eq/lt=%b, required %b", e.name, {bus2.gt, bus2.eq, bus2.lt}, e.res);
                end
                $display("txn w2 %s res=%b lat=%0d exp_res=%b exp_lat=%0d",
                         e.name, {bus2.gt, bus2.eq, bus2.lt}, cyc, e.res, e.lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_exhaustive_w2();
        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
